// File: rtl/sha256_pkg.sv
// Shared SHA-224/SHA-256 constants, FSM state type and round-function helpers.
// The SHA-224 IV is only referenced by the core when SHA256_MULTIROUND_SHA224_EN is defined.
package sha256_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRounds,
    StDone
  } state_e;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] Sha256Iv [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] Sha224Iv [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_w_window.sv
// 16-word sliding message-schedule window; presents W[t..t+R-1] and advances R words per cycle.
module sha256_w_window
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          load_i,
  input  logic                          adv_i,
  input  logic [511:0]                  block_i,
  output logic [ROUNDS_PER_CYCLE*32-1:0] w_o
);

  localparam int unsigned R = ROUNDS_PER_CYCLE;

  logic [31:0] w_q [16];
  logic [31:0] ext [16+R];

  // New words chain: with R > 2 later words depend on words generated this same cycle.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      ext[i] = w_q[i];
    end
    for (int j = 0; j < int'(R); j++) begin
      ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j] + small_sigma0(ext[1+j]) + ext[j];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_q <= '{default: '0};
    end else if (load_i) begin
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= block_i[511-32*i -: 32];
      end
    end else if (adv_i) begin
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= ext[i+R];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < int'(R); j++) begin
      w_o[j*32 +: 32] = w_q[j];
    end
  end

endmodule

// File: rtl/sha256_multiround_core.sv
// SHA-256 compression core running 1, 2 or 4 rounds per clock with digest chaining and abort.
// Optional SHA-224 mode enabled by defining SHA256_MULTIROUND_SHA224_EN.
module sha256_multiround_core
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic         next,
  input  logic         mode,
  input  logic         abort,
  input  logic [511:0] block,
  output logic         ready,
  output logic [255:0] digest,
  output logic         digest_valid
);

  localparam int unsigned R = ROUNDS_PER_CYCLE;
  localparam logic [5:0] LastCtr = 6'(64 - R);

  if (!(R == 1 || R == 2 || R == 4)) begin : gen_bad_rounds
    $error("ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  state_e      state_q, state_d;
  logic [5:0]  ctr_q, ctr_d;
  logic [31:0] h_q [8];
  logic [31:0] h_d [8];
  logic [31:0] wv_q [8];
  logic [31:0] wv_d [8];
  logic        dv_q, dv_d;
  logic        w_load, w_adv;
  logic [R*32-1:0] w_cur;
  logic [31:0] rv [R+1][8];
  logic [31:0] t1 [R];
  logic [31:0] t2 [R];

`ifdef SHA256_MULTIROUND_SHA224_EN
  logic mode_q, mode_d;
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  sha256_w_window #(
    .ROUNDS_PER_CYCLE(R)
  ) u_w_window (
    .clk    (clk),
    .reset_n(reset_n),
    .load_i (w_load),
    .adv_i  (w_adv),
    .block_i(block),
    .w_o    (w_cur)
  );

  // R chained rounds; rv[j] holds a..h before round ctr+j.
  always_comb begin
    rv[0] = wv_q;
    for (int j = 0; j < int'(R); j++) begin
      t1[j] = rv[j][7] + big_sigma1(rv[j][4]) + ch(rv[j][4], rv[j][5], rv[j][6]) +
              K[ctr_q + 6'(j)] + w_cur[j*32 +: 32];
      t2[j] = big_sigma0(rv[j][0]) + maj(rv[j][0], rv[j][1], rv[j][2]);
      rv[j+1][0] = t1[j] + t2[j];
      rv[j+1][1] = rv[j][0];
      rv[j+1][2] = rv[j][1];
      rv[j+1][3] = rv[j][2];
      rv[j+1][4] = rv[j][3] + t1[j];
      rv[j+1][5] = rv[j][4];
      rv[j+1][6] = rv[j][5];
      rv[j+1][7] = rv[j][6];
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    h_d     = h_q;
    wv_d    = wv_q;
    dv_d    = dv_q;
    w_load  = 1'b0;
    w_adv   = 1'b0;
`ifdef SHA256_MULTIROUND_SHA224_EN
    mode_d  = mode_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (init || next) begin
          if (init) begin
            h_d = Sha256Iv;
`ifdef SHA256_MULTIROUND_SHA224_EN
            if (!mode) h_d = Sha224Iv;
            mode_d = mode;
`endif
          end
          wv_d    = h_d;
          w_load  = 1'b1;
          ctr_d   = '0;
          dv_d    = 1'b0;
          state_d = StRounds;
        end
      end
      StRounds: begin
        if (abort) begin
          state_d = StIdle;
          dv_d    = 1'b0;
        end else begin
          wv_d  = rv[R];
          ctr_d = ctr_q + 6'(R);
          w_adv = 1'b1;
          if (ctr_q == LastCtr) state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        // Abort drops the feed-forward so H keeps its value from accept.
        if (abort) begin
          dv_d = 1'b0;
        end else begin
          for (int i = 0; i < 8; i++) begin
            h_d[i] = h_q[i] + wv_q[i];
          end
          dv_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ctr_q   <= '0;
      h_q     <= '{default: '0};
      wv_q    <= '{default: '0};
      dv_q    <= 1'b0;
`ifdef SHA256_MULTIROUND_SHA224_EN
      mode_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      h_q     <= h_d;
      wv_q    <= wv_d;
      dv_q    <= dv_d;
`ifdef SHA256_MULTIROUND_SHA224_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign ready        = (state_q == StIdle);
  assign digest_valid = dv_q;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      digest[255-32*i -: 32] = h_q[i];
    end
`ifdef SHA256_MULTIROUND_SHA224_EN
    if (!mode_q) digest[31:0] = '0;
`endif
  end

endmodule

// File: tb/tb_sha256_multiround_core.sv
// Bench for sha256_multiround_core: R=1,2,4 instances against a reference hash/timing model.
module tb_sha256_multiround_core;

  localparam int NDut = 3;

  localparam logic [255:0] Iv256 =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] Iv224 =
    256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
  localparam logic [255:0] DigAbc =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DigAbc224 =
    256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7_00000000;
  localparam logic [255:0] DigTwo =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] DigHello =
    256'hdffd6021bb2bd5b0af676290809ec3a53191dd81c7f70a4b28688a362182986f;

  localparam logic [511:0] BlkAbc = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BlkTwo1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BlkTwo2 = {480'h0, 32'h000001c0};
  localparam logic [511:0] BlkHello = {32'h48656c6c, 32'h6f2c2057, 32'h6f726c64,
                                       32'h21800000, 352'h0, 32'h00000068};

  localparam logic [31:0] Kt [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         init = 1'b0;
  logic         next = 1'b0;
  logic         mode = 1'b1;
  logic         abort = 1'b0;
  logic [511:0] block = '0;

  logic         ready_w [NDut];
  logic         dv_w    [NDut];
  logic [255:0] dig_w   [NDut];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDut; g++) begin : gen_dut
    sha256_multiround_core #(
      .ROUNDS_PER_CYCLE(1 << g)
    ) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .init        (init),
      .next        (next),
      .mode        (mode),
      .abort       (abort),
      .block       (block),
      .ready       (ready_w[g]),
      .digest      (dig_w[g]),
      .digest_valid(dv_w[g])
    );
  end

  // Plain textbook SHA-256 compression, including the final feed-forward add.
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, tt1, tt2;
    logic [255:0] hout;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      tt1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) +
            ((v[4] & v[5]) ^ (~v[4] & v[6])) + Kt[t] + w[t];
      tt2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) +
            ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + tt1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = tt1 + tt2;
    end
    for (int i = 0; i < 8; i++) hout[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return hout;
  endfunction

  // Reference model: block-level hash plus a countdown of 64/R+1 edges after accept.
  logic [255:0] m_h    [NDut];
  logic [255:0] m_pend [NDut];
  int           m_rem  [NDut];
  bit           m_busy [NDut];
  bit           m_dv   [NDut];
  bit           m_mode [NDut];

  function automatic logic mode_eff();
`ifdef SHA256_MULTIROUND_SHA224_EN
    return mode;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [255:0] start_h(input int g);
    if (!init) return m_h[g];
    return mode_eff() ? Iv256 : Iv224;
  endfunction

  function automatic logic [255:0] exp_digest(input int g);
    return m_mode[g] ? m_h[g] : {m_h[g][255:32], 32'h0};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    for (int g = 0; g < NDut; g++) begin
      if (!reset_n) begin
        m_h[g] <= '0; m_pend[g] <= '0; m_rem[g] <= 0;
        m_busy[g] <= 1'b0; m_dv[g] <= 1'b0; m_mode[g] <= 1'b1;
      end else if (!m_busy[g]) begin
        if (init || next) begin
          if (init) m_mode[g] <= mode_eff();
          m_h[g]    <= start_h(g);
          m_pend[g] <= sha_compress(start_h(g), block);
          m_rem[g]  <= 64 / (1 << g) + 1;
          m_busy[g] <= 1'b1;
          m_dv[g]   <= 1'b0;
        end
      end else if (abort) begin
        m_busy[g] <= 1'b0;
        m_dv[g]   <= 1'b0;
      end else if (m_rem[g] == 1) begin
        m_h[g]    <= m_pend[g];
        m_dv[g]   <= 1'b1;
        m_busy[g] <= 1'b0;
      end else begin
        m_rem[g] <= m_rem[g] - 1;
      end
    end
  end

  task automatic check(input string nm, input int g, input logic [255:0] act,
                       input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h expected %h", nm, g, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < NDut; g++) begin
        check("ready", g, 256'(ready_w[g]), 256'(!m_busy[g]));
        check("digest_valid", g, 256'(dv_w[g]), 256'(m_dv[g]));
        check("digest", g, dig_w[g], exp_digest(g));
      end
    end
  end

  task automatic accept(input logic i_init, input logic i_next, input logic i_mode,
                        input logic [511:0] blk);
    @(negedge clk);
    init = i_init; next = i_next; mode = i_mode; block = blk;
    @(negedge clk);
    init = 1'b0; next = 1'b0;
  endtask

  // Called on the negedge right after the accept edge; edge counting includes the accept edge.
  task automatic wait_done(input int pulse_at);
    int edges;
    int lat [NDut];
    bit seen [NDut];
    bit all_seen;
    edges = 1;
    for (int g = 0; g < NDut; g++) begin lat[g] = -1; seen[g] = 1'b0; end
    while (edges < 150) begin
      if (pulse_at != 0 && edges == pulse_at) begin init = 1'b1; block = BlkHello; end
      if (pulse_at != 0 && edges == pulse_at + 1) init = 1'b0;
      all_seen = 1'b1;
      for (int g = 0; g < NDut; g++) begin
        if (!seen[g] && ready_w[g]) begin seen[g] = 1'b1; lat[g] = edges; end
        all_seen &= seen[g];
      end
      if (all_seen) break;
      @(negedge clk);
      edges++;
    end
    for (int g = 0; g < NDut; g++) check("latency", g, 256'(lat[g]), 256'(64 / (1 << g) + 2));
  endtask

  task automatic check_all(input string nm, input logic [255:0] exp_dig, input logic exp_dv);
    for (int g = 0; g < NDut; g++) begin
      check({nm, "_digest"}, g, dig_w[g], exp_dig);
      check({nm, "_valid"}, g, 256'(dv_w[g]), 256'(exp_dv));
      check({nm, "_ready"}, g, 256'(ready_w[g]), 256'(1));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all("reset", 256'h0, 1'b0);
    #2 reset_n = 1'b1;
    chk_en = 1'b1;

    check("model_abc", 0, sha_compress(Iv256, BlkAbc), DigAbc);
    check("model_two", 0, sha_compress(sha_compress(Iv256, BlkTwo1), BlkTwo2), DigTwo);
    check("model_hello", 0, sha_compress(Iv256, BlkHello), DigHello);

    // next straight after reset chains from H = 0
    accept(1'b0, 1'b1, 1'b1, BlkAbc);
    wait_done(0);
    check_all("next_from_zero", sha_compress(256'h0, BlkAbc), 1'b1);

    accept(1'b1, 1'b0, 1'b1, BlkAbc);
    wait_done(0);
    check_all("abc", DigAbc, 1'b1);

    accept(1'b1, 1'b0, 1'b1, BlkTwo1);
    wait_done(0);
    check_all("two_mid", sha_compress(Iv256, BlkTwo1), 1'b1);
    accept(1'b0, 1'b1, 1'b1, BlkTwo2);
    wait_done(0);
    check_all("two_final", DigTwo, 1'b1);

    accept(1'b1, 1'b0, 1'b0, BlkAbc);
    wait_done(0);
`ifdef SHA256_MULTIROUND_SHA224_EN
    check_all("abc224", DigAbc224, 1'b1);
`else
    check_all("abc_mode0", DigAbc, 1'b1);
`endif

    // init while busy is ignored
    accept(1'b1, 1'b0, 1'b1, BlkAbc);
    wait_done(10);
    check_all("init_busy", DigAbc, 1'b1);

    // abort mid-rounds leaves H at the IV
    accept(1'b1, 1'b0, 1'b1, BlkAbc);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_all("abort", Iv256, 1'b0);
    accept(1'b1, 1'b0, 1'b1, BlkHello);
    wait_done(0);
    check_all("hello", DigHello, 1'b1);

    // abort while idle has no effect
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_all("abort_idle", DigHello, 1'b1);

    // asynchronous reset mid-block
    accept(1'b1, 1'b0, 1'b1, BlkAbc);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_all("async_reset", 256'h0, 1'b0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
